signed_round_sat_pipe: RTL and testbench

- Multi-lane signed fixed-point narrowing stage with a runtime-selectable rounding mode and saturation.
- Drops FRACWIDTH = DATA_WIDTH_IN-DATA_WIDTH_OUT LSBs per lane, rounds, clamps to the output range, and reports per-lane saturation.
- Two-stage pipeline with valid/ready backpressure and a sticky saturation-event counter.
- Sits between wide DSP accumulators (FIR/MAC outputs) and narrower downstream datapaths.

---
 rtl/signed_round_sat_pipe_pkg.sv | 23 ++
 rtl/signed_round_sat_pipe_if.sv | 35 +++
 rtl/signed_round_sat_pipe_round_lane.sv | 49 ++++
 rtl/signed_round_sat_pipe.sv | 121 ++++++++++++
 tb/tb_signed_round_sat_pipe.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/signed_round_sat_pipe_pkg.sv
// Shared types and helpers for the signed rounding/saturation pipeline.
// Holds the rounding-mode encoding and two's-complement range helpers.
// No ports; imported by the interface, the lane rounder and the top.
package round_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_TO_ZERO   = 2'd3
    } round_mode_t;

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/signed_round_sat_pipe_if.sv
// Bus bundle for the rounding/saturation pipeline: input beat, output beat,
// counter clear and readback. Latency: none (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes.
interface signed_round_sat_pipe_if #(
    parameter int DATA_WIDTH_IN  = 24,
    parameter int DATA_WIDTH_OUT = 16,
    parameter int NUM_CH         = 4,
    parameter int SAT_CNT_W      = 16
);
    import round_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    round_mode_t                        in_mode;
    logic [NUM_CH*DATA_WIDTH_IN-1:0]    din;
    logic                               out_valid;
    logic                               out_ready;
    logic [NUM_CH*DATA_WIDTH_OUT-1:0]   dout;
    logic [NUM_CH-1:0]                  sat_flags;
    logic                               sat_clr;
    logic [SAT_CNT_W-1:0]               sat_count;

    // Producer/consumer side (drives beats in, accepts beats out).
    modport master (
        output in_valid, in_mode, din, out_ready, sat_clr,
        input  in_ready, out_valid, dout, sat_flags, sat_count
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_mode, din, out_ready, sat_clr,
        output in_ready, out_valid, dout, sat_flags, sat_count
    );

endinterface

// File: rtl/signed_round_sat_pipe_round_lane.sv
// Per-lane rounder: drops the fractional LSBs and applies the rounding increment.
// Latency: combinational. Backpressure: none (pure function of din_i/mode_i).
// Ports: din_i signed lane, mode_i rounding mode, r_o rounded value one bit wider than output.
module round_lane
    import round_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 24,
    parameter int DATA_WIDTH_OUT = 16
) (
    input  logic [DATA_WIDTH_IN-1:0]  din_i,
    input  round_mode_t               mode_i,
    output logic [DATA_WIDTH_OUT:0]   r_o
);
    localparam int FW = DATA_WIDTH_IN - DATA_WIDTH_OUT;

    generate
        if (FW == 0) begin : g_pass
            // Nothing to drop: sign-extend by one bit and ignore the mode.
            logic unused_mode;
            assign unused_mode = ^mode_i;
            assign r_o = {din_i[DATA_WIDTH_IN-1], din_i};
        end else begin : g_round
            localparam logic [FW-1:0] HALF = FW'(1) << (FW - 1);

            logic [DATA_WIDTH_OUT-1:0] q;   // floor(din / 2^FW)
            logic [FW-1:0]             f;   // discarded fraction
            logic                      inc;

            // Taking the upper bits is an arithmetic shift right, i.e. floor.
            assign q = din_i[DATA_WIDTH_IN-1:FW];
            assign f = din_i[FW-1:0];

            always_comb begin
                inc = 1'b0;
                case (mode_i)
                    RND_TRUNC:     inc = 1'b0;
                    RND_HALF_UP:   inc = (f >= HALF);
                    RND_HALF_EVEN: inc = (f > HALF) || ((f == HALF) && q[0]);
                    RND_TO_ZERO:   inc = din_i[DATA_WIDTH_IN-1] && (f != '0);
                    default:       inc = 1'b0;
                endcase
            end

            // One guard bit so q=max plus inc is seen as overflow, not wrap.
            assign r_o = {q[DATA_WIDTH_OUT-1], q} + {{DATA_WIDTH_OUT{1'b0}}, inc};
        end
    endgenerate

endmodule

// File: rtl/signed_round_sat_pipe.sv
// Multi-lane signed narrowing: round (stage 1), saturate + flag (stage 2), sticky sat counter.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle. Backpressure: skid-free valid/ready,
// in_ready = !s1_valid || stage-2 load (combinational from out_ready). Ports: clk, rst_n, bus (slave).
module signed_round_sat_pipe
    import round_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 24,
    parameter int DATA_WIDTH_OUT = 16,
    parameter int NUM_CH         = 4,
    parameter int SAT_CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    signed_round_sat_pipe_if.slave  bus
);
    localparam int RW  = DATA_WIDTH_OUT + 1;
    localparam int DWO = DATA_WIDTH_OUT;
    localparam logic signed [63:0] SMAX = sat_max(DATA_WIDTH_OUT);
    localparam logic signed [63:0] SMIN = sat_min(DATA_WIDTH_OUT);

    generate
        if (DATA_WIDTH_IN <= 0) begin : g_err_win
            $error("DATA_WIDTH_IN must be > 0");
        end
        if (DATA_WIDTH_OUT <= 0 || DATA_WIDTH_OUT > DATA_WIDTH_IN || DATA_WIDTH_OUT > 62) begin : g_err_wout
            $error("DATA_WIDTH_OUT must be in 1..min(DATA_WIDTH_IN,62)");
        end
        if (NUM_CH < 1) begin : g_err_ch
            $error("NUM_CH must be >= 1");
        end
        if (SAT_CNT_W < 1) begin : g_err_cnt
            $error("SAT_CNT_W must be >= 1");
        end
    endgenerate

    logic [NUM_CH*RW-1:0]  lane_r;
    logic                  s1_valid_q, s1_valid_d;
    logic [NUM_CH*RW-1:0]  s1_r_q, s1_r_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [NUM_CH*DWO-1:0] dout_q, dout_d;
    logic [NUM_CH-1:0]     flags_q, flags_d;
    logic [SAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH*DWO-1:0] sat_dat;
    logic [NUM_CH-1:0]     sat_flg;
    logic                  s1_load, s2_load;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        round_lane #(
            .DATA_WIDTH_IN  (DATA_WIDTH_IN),
            .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
        ) u_lane (
            .din_i  (bus.din[k*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
            .mode_i (bus.in_mode),
            .r_o    (lane_r[k*RW +: RW])
        );
    end

    assign s2_load      = !s2_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_load;
    assign bus.in_ready = s1_load;

    // Full-width signed compare against the output range of each lane.
    always_comb begin
        sat_dat = '0;
        sat_flg = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic [RW-1:0]      r_k;
            logic signed [63:0] r_ext;
            r_k   = s1_r_q[k*RW +: RW];
            r_ext = {{(64-RW){r_k[RW-1]}}, r_k};
            if (r_ext > SMAX) begin
                sat_dat[k*DWO +: DWO] = SMAX[DWO-1:0];
                sat_flg[k]            = 1'b1;
            end else if (r_ext < SMIN) begin
                sat_dat[k*DWO +: DWO] = SMIN[DWO-1:0];
                sat_flg[k]            = 1'b1;
            end else begin
                sat_dat[k*DWO +: DWO] = r_k[DWO-1:0];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
        s1_r_d     = (s1_load && bus.in_valid) ? lane_r : s1_r_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        dout_d     = (s2_load && s1_valid_q) ? sat_dat : dout_q;
        flags_d    = (s2_load && s1_valid_q) ? sat_flg : flags_q;
        cnt_d      = cnt_q;
        // Clear beats a same-cycle increment; the counter sticks at all-ones.
        if (bus.sat_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q && bus.out_ready && (|flags_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            dout_q     <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            dout_q     <= dout_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.dout      = dout_q;
    assign bus.sat_flags = flags_q;
    assign bus.sat_count = cnt_q;

endmodule

// File: tb/tb_signed_round_sat_pipe.sv
// Bench for signed_round_sat_pipe: 8->4 bit two-lane instance and 8->8 pass-through instance.
// Expected beats are queued at acceptance; monitors pop and compare on each output transfer.
`timescale 1ns/1ps
module tb_signed_round_sat_pipe;
    import round_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    signed_round_sat_pipe_if #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(4), .NUM_CH(2), .SAT_CNT_W(2)) ifa ();
    signed_round_sat_pipe_if #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(8), .NUM_CH(1), .SAT_CNT_W(4)) ifb ();

    signed_round_sat_pipe #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(4), .NUM_CH(2), .SAT_CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    signed_round_sat_pipe #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(8), .NUM_CH(1), .SAT_CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct {
        logic [7:0] d;
        logic [1:0] f;
        int         acc;
        bit         lat;
    } exp_a_t;

    exp_a_t     qa[$];
    logic [7:0] qb[$];
    bit         b_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin : mon_a
        exp_a_t e;
        if (rst_n && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_beat", ifa.out_valid, 0);
            end else begin
                e = qa.pop_front();
                check("a_dout", ifa.dout, e.d);
                check("a_sat_flags", ifa.sat_flags, e.f);
                if (e.lat) check("a_latency", cyc - e.acc, 2);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin : mon_b
        logic [7:0] e;
        if (rst_n && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_beat", ifb.out_valid, 0);
            end else begin
                e = qb.pop_front();
                check("b_dout", ifb.dout, e);
                check("b_sat_flags", ifb.sat_flags, 0);
            end
        end
    end

    // Offer one beat to A; returns #1 after the accepting edge.
    task automatic send_a(input logic [1:0] m, input logic [15:0] d, input logic [7:0] ed,
                          input logic [1:0] ef, input bit lat, input bit track);
        exp_a_t e;
        int t;
        t = 0;
        ifa.in_valid = 1'b1;
        ifa.in_mode  = round_mode_t'(m);
        ifa.din      = d;
        @(negedge clk);
        while (!ifa.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ifa.in_ready) begin
            check("a_accept_timeout", ifa.in_ready, 1);
        end else if (track) begin
            e.d = ed; e.f = ef; e.acc = cyc; e.lat = lat;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [1:0] m);
        int t;
        t = 0;
        ifb.in_valid = 1'b1;
        ifb.in_mode  = round_mode_t'(m);
        ifb.din      = d;
        @(negedge clk);
        while (!ifb.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ifb.in_ready) check("b_accept_timeout", ifb.in_ready, 1);
        else qb.push_back(d);
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int t;
        t = 0;
        while (qa.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("a_drain", qa.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        ifa.in_valid = 1'b0; ifa.in_mode = RND_TRUNC; ifa.din = '0; ifa.out_ready = 1'b1; ifa.sat_clr = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_mode = RND_TRUNC; ifb.din = '0; ifb.out_ready = 1'b1; ifb.sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_dout", ifa.dout, 0);
        check("rst_sat_flags", ifa.sat_flags, 0);
        check("rst_sat_count", ifa.sat_count, 0);
        check("rst_in_ready", ifa.in_ready, 1);
        @(posedge clk); #1;

        // Rounding modes on +2.5 (lane 0) and -2.5 (lane 1), then saturation corners.
        send_a(2'd0, 16'hD828, 8'hD2, 2'b00, 1, 1);
        send_a(2'd1, 16'hD828, 8'hE3, 2'b00, 1, 1);
        send_a(2'd2, 16'hD828, 8'hE2, 2'b00, 1, 1);
        send_a(2'd3, 16'hD828, 8'hE2, 2'b00, 1, 1);
        send_a(2'd2, 16'h807F, 8'h87, 2'b01, 1, 1);
        send_a(2'd1, 16'h8080, 8'h88, 2'b00, 1, 1);
        send_a(2'd3, 16'h8080, 8'h88, 2'b00, 1, 1);
        send_a(2'd0, 16'h7F7F, 8'h77, 2'b00, 1, 1);
        drain_a();
        check("cnt_after_modes", ifa.sat_count, 1);

        // Backpressure: two beats fill the pipe, then in_ready must drop and dout hold.
        @(posedge clk); #1 ifa.out_ready = 1'b0;
        send_a(2'd0, 16'hD828, 8'hD2, 2'b00, 0, 1);
        send_a(2'd1, 16'hD828, 8'hE3, 2'b00, 0, 1);
        @(negedge clk);
        check("bp_in_ready_low", ifa.in_ready, 0);
        check("bp_out_valid", ifa.out_valid, 1);
        check("bp_dout_head", ifa.dout, 8'hD2);
        fork
            begin
                send_a(2'd2, 16'hD828, 8'hE2, 2'b00, 0, 1);
                send_a(2'd1, 16'h7F7F, 8'h77, 2'b11, 0, 1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_dout_stable", ifa.dout, 8'hD2);
                    check("bp_valid_stable", ifa.out_valid, 1);
                    check("bp_in_ready_held", ifa.in_ready, 0);
                end
                @(posedge clk); #1 ifa.out_ready = 1'b1;
            end
        join
        drain_a();
        check("cnt_after_bp", ifa.sat_count, 2);

        // Counter: clear, then 5 saturating beats on a 2-bit counter must stick at 3.
        @(posedge clk); #1 ifa.sat_clr = 1'b1;
        @(posedge clk); #1 ifa.sat_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr", ifa.sat_count, 0);
        @(posedge clk); #1;
        repeat (5) send_a(2'd1, 16'h7F7F, 8'h77, 2'b11, 0, 1);
        drain_a();
        check("cnt_sticky_max", ifa.sat_count, 3);

        // Clear in the same cycle as a saturating transfer: clear wins.
        @(posedge clk); #1 ifa.out_ready = 1'b0;
        send_a(2'd1, 16'h7F7F, 8'h77, 2'b11, 0, 1);
        t = 0;
        @(negedge clk);
        while (!ifa.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cnt_wait_valid", ifa.out_valid, 1);
        @(posedge clk); #1 ifa.out_ready = 1'b1; ifa.sat_clr = 1'b1;
        @(posedge clk); #1 ifa.sat_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_wins", ifa.sat_count, 0);
        @(posedge clk); #1;
        send_a(2'd2, 16'h807F, 8'h87, 2'b01, 0, 1);
        drain_a();
        check("cnt_inc_after_clr", ifa.sat_count, 1);

        // Reset with two beats in flight: everything cleared, nothing emerges later.
        @(posedge clk); #1 ifa.out_ready = 1'b0;
        send_a(2'd2, 16'h807F, 8'h00, 2'b00, 0, 0);
        send_a(2'd0, 16'hD828, 8'h00, 2'b00, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rstf_out_valid", ifa.out_valid, 0);
        check("rstf_dout", ifa.dout, 0);
        check("rstf_sat_flags", ifa.sat_flags, 0);
        check("rstf_sat_count", ifa.sat_count, 0);
        @(posedge clk); #1 rst_n = 1'b1; ifa.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rstf_in_ready", ifa.in_ready, 1);
        check("rstf_no_output", ifa.out_valid, 0);
        check("rstf_queue_empty", qa.size(), 0);

        // Pass-through instance: random data and modes, random downstream stalls.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 40; i++) send_b(8'($urandom), 2'($urandom));
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1 ifb.out_ready = 1'($urandom_range(0, 1));
                end
                ifb.out_ready = 1'b1;
            end
        join
        t = 0;
        while (qb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("b_drain", qb.size(), 0);
        @(posedge clk); @(negedge clk);
        check("b_sat_count", ifb.sat_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
